// File: rtl/pwm_pkg.sv
// Shared constants and channel state type for the multi-channel PWM controller.
package pwm_pkg;

  localparam int DUTY_MAX  = 100;
  localparam int DUTY_W    = 7;
  localparam int PHASE_MAX = 99;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } ch_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: target/effective duty, start/stop FSM and phase comparator.
// With PWM_RAMP_EN defined the effective duty ramps one step every RAMP_PERIODS periods.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int DUTY_STEP = 10
`ifdef PWM_RAMP_EN
  , parameter int RAMP_PERIODS = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              boundary_i,
  input  logic [DUTY_W-1:0] phase_i,
  output logic              pwm_o,
  output logic              running_o,
  output logic [DUTY_W-1:0] target_o,
  output logic [DUTY_W-1:0] eff_o
);

  localparam logic [7:0] STEP = 8'(DUTY_STEP);
  localparam logic [7:0] MAX8 = 8'(DUTY_MAX);

  ch_state_e         state_q, state_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] eff_q, eff_d, goal;
  logic [7:0]        tgt_up, tgt_dn;
  logic              pwm_q, running_q;
  logic              start_ok, stop_ok;

`ifdef PWM_RAMP_EN
  localparam int RW = $clog2(RAMP_PERIODS + 1);
  logic [RW-1:0] ramp_q, ramp_d;
  logic          ramp_due;
  logic [7:0]    eff_up, eff_dn;
  assign ramp_due = (ramp_q == RW'(RAMP_PERIODS - 1));
`endif

  // Stop dominates a simultaneous start
  assign start_ok = sel_i && start_i && !stop_i;
  assign stop_ok  = sel_i && stop_i;

  always_comb begin
    tgt_up   = {1'b0, target_q} + STEP;
    tgt_dn   = {1'b0, target_q} - STEP;
    target_d = target_q;
    if (sel_i && inc_i && !dec_i)
      target_d = (tgt_up > MAX8) ? DUTY_W'(DUTY_MAX) : tgt_up[DUTY_W-1:0];
    else if (sel_i && dec_i && !inc_i)
      target_d = tgt_dn[7] ? '0 : tgt_dn[DUTY_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) target_q <= '0;
    else      target_q <= target_d;
  end

  always_comb begin
    goal  = (state_q == RUN) ? target_q : '0;
    eff_d = eff_q;
`ifdef PWM_RAMP_EN
    eff_up = {1'b0, eff_q} + STEP;
    eff_dn = {1'b0, eff_q} - STEP;
`endif
    if (state_q == IDLE) begin
      eff_d = '0;
    end else if (boundary_i) begin
`ifdef PWM_RAMP_EN
      if (ramp_due) begin
        if (eff_q < goal)
          eff_d = (eff_up > {1'b0, goal}) ? goal : eff_up[DUTY_W-1:0];
        else if (eff_dn[7] || (eff_dn[DUTY_W-1:0] < goal))
          eff_d = goal;
        else
          eff_d = eff_dn[DUTY_W-1:0];
      end
`else
      eff_d = goal;
`endif
    end

    state_d = state_q;
    case (state_q)
      IDLE:     if (start_ok) state_d = RUN;
      RUN:      if (stop_ok) state_d = STOPPING;
      STOPPING: begin
        if (start_ok)                        state_d = RUN;
        else if (boundary_i && eff_d == '0)  state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase

`ifdef PWM_RAMP_EN
    ramp_d = ramp_q;
    if (state_d != state_q)
      ramp_d = '0;
    else if (boundary_i && state_q != IDLE)
      ramp_d = ramp_due ? '0 : ramp_q + RW'(1);
`endif
  end

  // Effective duty only moves at a boundary, so every pulse is full width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      eff_q     <= '0;
      pwm_q     <= 1'b0;
      running_q <= 1'b0;
`ifdef PWM_RAMP_EN
      ramp_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      eff_q     <= eff_d;
      pwm_q     <= (phase_i < eff_q);
      running_q <= (state_d != IDLE);
`ifdef PWM_RAMP_EN
      ramp_q    <= ramp_d;
`endif
    end
  end

  assign pwm_o     = pwm_q;
  assign running_o = running_q;
  assign target_o  = target_q;
  assign eff_o     = eff_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM controller: shared prescaler/phase timebase, channel select decode
// and readback mux. Optional duty ramping is enabled by defining PWM_RAMP_EN.
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CH_W         = 2,
  parameter int PRESCALE     = 500,
  parameter int DUTY_STEP    = 10,
  parameter int RAMP_PERIODS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH_W-1:0]     ch_sel,
  input  logic                btn_increase,
  input  logic                btn_decrease,
  input  logic                btn_start,
  input  logic                btn_stop,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] motor_running,
  output logic [DUTY_W-1:0]   duty_target_sel,
  output logic [DUTY_W-1:0]   duty_eff_sel,
  output logic                period_start
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   presc_q;
  logic [DUTY_W-1:0] phase_q;
  logic              period_start_q;
  logic              tick, boundary, sel_valid;
  logic [CHANNELS-1:0] sel_hit;
  logic [DUTY_W-1:0] target_arr [CHANNELS];
  logic [DUTY_W-1:0] eff_arr    [CHANNELS];

  assign tick      = (presc_q == PS_W'(PRESCALE - 1));
  assign boundary  = tick && (phase_q == DUTY_W'(PHASE_MAX));
  assign sel_valid = ({{(32-CH_W){1'b0}}, ch_sel} < 32'(CHANNELS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q        <= '0;
      phase_q        <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= tick ? '0 : presc_q + PS_W'(1);
      if (tick)
        phase_q <= (phase_q == DUTY_W'(PHASE_MAX)) ? '0 : phase_q + DUTY_W'(1);
      period_start_q <= boundary;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign sel_hit[i] = sel_valid && (ch_sel == CH_W'(i));

    pwm_channel #(
      .DUTY_STEP(DUTY_STEP)
`ifdef PWM_RAMP_EN
      , .RAMP_PERIODS(RAMP_PERIODS)
`endif
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .sel_i      (sel_hit[i]),
      .inc_i      (btn_increase),
      .dec_i      (btn_decrease),
      .start_i    (btn_start),
      .stop_i     (btn_stop),
      .boundary_i (boundary),
      .phase_i    (phase_q),
      .pwm_o      (pwm_out[i]),
      .running_o  (motor_running[i]),
      .target_o   (target_arr[i]),
      .eff_o      (eff_arr[i])
    );
  end

`ifndef PWM_RAMP_EN
  // Ramp configuration is inert in this build
  logic ramp_cfg_unused;
  assign ramp_cfg_unused = (RAMP_PERIODS < 1);
`endif

  always_comb begin
    duty_target_sel = '0;
    duty_eff_sel    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_hit[i]) begin
        duty_target_sel = target_arr[i];
        duty_eff_sel    = eff_arr[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed self-checking bench for pwm_multi_ctrl (4 channels, PRESCALE=2, 200 clk per period).
// Ramp expectations are used when PWM_RAMP_EN is defined.
module tb_pwm_multi_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] chSel;
  logic       btnIncrease, btnDecrease, btnStart, btnStop;
  logic [3:0] pwmOut, motorRunning;
  logic [6:0] dutyTargetSel, dutyEffSel;
  logic       periodStart;

  int         checkCount = 0;
  int         errorCount = 0;
  int         hiCnt [4];
  logic [3:0] lateRun;

`ifdef PWM_RAMP_EN
  localparam logic [3:0] EXP_RUN = 4'b0000;
`else
  localparam logic [3:0] EXP_RUN = 4'b0011;
`endif

  pwm_multi_ctrl #(
    .CHANNELS(4), .CH_W(3), .PRESCALE(2), .DUTY_STEP(10), .RAMP_PERIODS(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ch_sel          (chSel),
    .btn_increase    (btnIncrease),
    .btn_decrease    (btnDecrease),
    .btn_start       (btnStart),
    .btn_stop        (btnStop),
    .pwm_out         (pwmOut),
    .motor_running   (motorRunning),
    .duty_target_sel (dutyTargetSel),
    .duty_eff_sel    (dutyEffSel),
    .period_start    (periodStart)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge; holds the pulse across exactly one rising edge
  task automatic applyStimulus(input logic [2:0] ch, input logic inc, input logic dec,
                               input logic start, input logic stop);
    chSel = ch; btnIncrease = inc; btnDecrease = dec; btnStart = start; btnStop = stop;
    @(negedge clk);
    btnIncrease = 1'b0; btnDecrease = 1'b0; btnStart = 1'b0; btnStop = 1'b0;
  endtask

  task automatic waitBoundary();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!periodStart && n < 400);
    if (!periodStart) checkOutput("boundary_timeout", 0, 1);
  endtask

  // Starts on the period_start negedge; samples the 200 clk of one period
  task automatic runPeriod(input int stopAt, input logic [2:0] stopCh);
    for (int c = 0; c < 4; c++) hiCnt[c] = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (pwmOut[c]) hiCnt[c]++;
      if (k == 199) lateRun = motorRunning;
      if (k == stopAt) begin
        chSel = stopCh; btnStop = 1'b1;
      end else begin
        btnStop = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0; chSel = '0;
    btnIncrease = 1'b0; btnDecrease = 1'b0; btnStart = 1'b0; btnStop = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pwm", 32'(pwmOut), 0);
    checkOutput("rst_running", 32'(motorRunning), 0);
    checkOutput("rst_period_start", 32'(periodStart), 0);
    checkOutput("rst_target", 32'(dutyTargetSel), 0);
    checkOutput("rst_eff", 32'(dutyEffSel), 0);
    rst = 1'b1;

    for (int j = 0; j < 3; j++) applyStimulus(3'd0, 1, 0, 0, 0);
    checkOutput("ch0_target30", 32'(dutyTargetSel), 30);
    applyStimulus(3'd0, 1, 1, 0, 0);
    checkOutput("ch0_incdec_same", 32'(dutyTargetSel), 30);

    for (int j = 0; j < 12; j++) applyStimulus(3'd1, 1, 0, 0, 0);
    checkOutput("ch1_sat100", 32'(dutyTargetSel), 100);
    for (int j = 0; j < 15; j++) applyStimulus(3'd1, 0, 1, 0, 0);
    checkOutput("ch1_sat0", 32'(dutyTargetSel), 0);

    applyStimulus(3'd3, 0, 0, 1, 1);
    checkOutput("ch3_startstop_idle", 32'(motorRunning), 0);

`ifdef PWM_RAMP_EN
    for (int j = 0; j < 4; j++) applyStimulus(3'd2, 1, 0, 0, 0);
    checkOutput("ch2_target40", 32'(dutyTargetSel), 40);
    applyStimulus(3'd2, 0, 0, 1, 0);
    for (int b = 1; b <= 8; b++) begin
      waitBoundary();
      checkOutput($sformatf("ramp_up_b%0d", b), 32'(dutyEffSel), 10 * (b / 2));
    end
    applyStimulus(3'd2, 0, 0, 0, 1);
    for (int b = 1; b <= 8; b++) begin
      waitBoundary();
      checkOutput($sformatf("ramp_dn_b%0d", b), 32'(dutyEffSel), 40 - 10 * (b / 2));
      checkOutput($sformatf("ramp_run_b%0d", b), 32'(motorRunning[2]), (b < 8) ? 1 : 0);
    end
`else
    applyStimulus(3'd0, 0, 0, 1, 0);
    checkOutput("ch0_running", 32'(motorRunning), 1);
    checkOutput("ch0_eff_before_bnd", 32'(dutyEffSel), 0);
    waitBoundary();
    checkOutput("ch0_eff_after_bnd", 32'(dutyEffSel), 30);
    runPeriod(0, 3'd0);
    checkOutput("ch0_high_clk", hiCnt[0], 60);
    checkOutput("ch1_idle_low", hiCnt[1], 0);
    checkOutput("ch2_idle_low", hiCnt[2], 0);
    checkOutput("ch3_idle_low", hiCnt[3], 0);

    for (int j = 0; j < 10; j++) applyStimulus(3'd1, 1, 0, 0, 0);
    checkOutput("ch1_target100", 32'(dutyTargetSel), 100);
    applyStimulus(3'd1, 0, 0, 1, 0);
    waitBoundary();
    runPeriod(0, 3'd1);
    checkOutput("ch1_const_high", hiCnt[1], 200);
    checkOutput("ch0_undisturbed", hiCnt[0], 60);
    for (int j = 0; j < 15; j++) applyStimulus(3'd1, 0, 1, 0, 0);
    checkOutput("ch1_no_underflow", 32'(dutyTargetSel), 0);
    waitBoundary();
    runPeriod(0, 3'd1);
    checkOutput("ch1_zero_low", hiCnt[1], 0);
    checkOutput("running_ch0_ch1", 32'(motorRunning), 3);

    for (int j = 0; j < 5; j++) applyStimulus(3'd2, 1, 0, 0, 0);
    checkOutput("ch2_target50", 32'(dutyTargetSel), 50);
    applyStimulus(3'd2, 0, 0, 1, 0);
    waitBoundary();
    runPeriod(40, 3'd2);
    checkOutput("ch2_full_pulse", hiCnt[2], 100);
    checkOutput("ch2_stopping_running", 32'(lateRun[2]), 1);
    checkOutput("ch2_boundary", 32'(periodStart), 1);
    checkOutput("ch2_idle_after_bnd", 32'(motorRunning[2]), 0);
    checkOutput("ch0_during_ch2", hiCnt[0], 60);
`endif

    applyStimulus(3'd5, 1, 0, 0, 0);
    applyStimulus(3'd5, 0, 0, 1, 0);
    checkOutput("sel5_target", 32'(dutyTargetSel), 0);
    checkOutput("sel5_eff", 32'(dutyEffSel), 0);
    checkOutput("sel5_running", 32'(motorRunning), 32'(EXP_RUN));
    chSel = 3'd1;
    #1;
    checkOutput("sel5_no_alias_ch1", 32'(dutyTargetSel), 0);
    chSel = 3'd3;
    #1;
    checkOutput("sel5_ch3_target", 32'(dutyTargetSel), 0);

    waitBoundary();
    repeat (10) @(negedge clk);
`ifndef PWM_RAMP_EN
    checkOutput("pre_reset_ch0_high", 32'(pwmOut[0]), 1);
`endif
    chSel = 3'd0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_pwm", 32'(pwmOut), 0);
    checkOutput("async_rst_running", 32'(motorRunning), 0);
    checkOutput("async_rst_period_start", 32'(periodStart), 0);
    checkOutput("async_rst_target", 32'(dutyTargetSel), 0);
    checkOutput("async_rst_eff", 32'(dutyEffSel), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
